// File: rtl/video_timing_if.sv
// video_timing_if: controls into, and raster/sync/pattern outputs out of, the video timing generator.
interface video_timing_if #(
   parameter int COLOR_DEPTH = 6
);
   logic                   enable;
   logic [2:0]             ce_divider;
   logic [1:0]             pattern_sel;
   logic                   ce_pix;
   logic [8:0]             hcnt;
   logic [8:0]             vcnt;
   logic                   hblank;
   logic                   vblank;
   logic                   HSync;
   logic                   VSync;
   logic                   frame_start;
   logic [COLOR_DEPTH-1:0] R;
   logic [COLOR_DEPTH-1:0] G;
   logic [COLOR_DEPTH-1:0] B;

   modport master (
      input  enable, ce_divider, pattern_sel,
      output ce_pix, hcnt, vcnt, hblank, vblank, HSync, VSync, frame_start, R, G, B
   );

   modport slave (
      output enable, ce_divider, pattern_sel,
      input  ce_pix, hcnt, vcnt, hblank, vblank, HSync, VSync, frame_start, R, G, B
   );
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: pixel enable, raster counters, blanking, sync and test pattern for the MiST video pipeline.
module video_timing_gen #(
   parameter int   COLOR_DEPTH = 6,
   parameter int   H_ACTIVE    = 256,
   parameter int   H_FP        = 24,
   parameter int   H_SYNC      = 32,
   parameter int   H_BP        = 72,
   parameter int   V_ACTIVE    = 224,
   parameter int   V_FP        = 16,
   parameter int   V_SYNC      = 3,
   parameter int   V_BP        = 19,
   parameter logic HS_POL      = 1'b0,
   parameter logic VS_POL      = 1'b0
) (
   input logic            clk_sys,
   input logic            reset_n,
   video_timing_if.master vif
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
   localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
   localparam logic [8:0] H_ACT  = 9'(H_ACTIVE);
   localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);
   localparam logic [8:0] HS_BEG = 9'(H_ACTIVE + H_FP);
   localparam logic [8:0] HS_END = 9'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [8:0] VS_BEG = 9'(V_ACTIVE + V_FP);
   localparam logic [8:0] VS_END = 9'(V_ACTIVE + V_FP + V_SYNC);

   if (H_TOTAL > 512 || V_TOTAL > 512) begin : g_size_chk
      $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 512");
   end

   logic [2:0]             div_q, div_d, lim;
   logic                   tick;
   logic                   started_q;
   logic [8:0]             hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic                   hblank_q, hblank_d, vblank_q, vblank_d;
   logic                   hsync_q, hsync_d, vsync_q, vsync_d;
   logic                   fs_q, fs_d;
   logic                   active, grid;
   logic [2:0]             bar;
   logic [COLOR_DEPTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

   // ">=" lets a lowered divider fire at once instead of wrapping the 3-bit counter
   always_comb begin
      lim      = (vif.ce_divider == 3'd0) ? 3'd3 : vif.ce_divider;
      tick     = vif.enable && (div_q >= lim);
      div_d    = !vif.enable ? div_q : tick ? 3'd0 : div_q + 3'd1;
      hcnt_d   = (!started_q || hcnt_q == H_LAST) ? 9'd0 : hcnt_q + 9'd1;
      vcnt_d   = !started_q ? 9'd0 : (hcnt_q != H_LAST) ? vcnt_q : (vcnt_q == V_LAST) ? 9'd0 : vcnt_q + 9'd1;
      fs_d     = tick && hcnt_d == 9'd0 && vcnt_d == 9'd0;
      hblank_d = hcnt_d >= H_ACT;
      vblank_d = vcnt_d >= V_ACT;
      hsync_d  = (hcnt_d >= HS_BEG && hcnt_d < HS_END) ? HS_POL : ~HS_POL;
      vsync_d  = (vcnt_d >= VS_BEG && vcnt_d < VS_END) ? VS_POL : ~VS_POL;
      active   = !hblank_d && !vblank_d;
      bar      = 3'((32'(hcnt_d) * 8) / H_ACTIVE);
      grid     = hcnt_d[3:0] == 4'd0 || vcnt_d[3:0] == 4'd0;
      r_d      = !active ? '0 : (vif.pattern_sel == 2'd1) ? {COLOR_DEPTH{bar[2]}} :
                 (vif.pattern_sel == 2'd2) ? {COLOR_DEPTH{grid}} :
                 (vif.pattern_sel == 2'd3) ? hcnt_d[COLOR_DEPTH-1:0] : '0;
      g_d      = !active ? '0 : (vif.pattern_sel == 2'd1) ? {COLOR_DEPTH{bar[1]}} :
                 (vif.pattern_sel == 2'd2) ? {COLOR_DEPTH{grid}} :
                 (vif.pattern_sel == 2'd3) ? vcnt_d[COLOR_DEPTH-1:0] : '0;
      b_d      = !active ? '0 : (vif.pattern_sel == 2'd1) ? {COLOR_DEPTH{bar[0]}} :
                 (vif.pattern_sel == 2'd2) ? {COLOR_DEPTH{grid}} :
                 (vif.pattern_sel == 2'd3) ? hcnt_d[COLOR_DEPTH-1:0] ^ vcnt_d[COLOR_DEPTH-1:0] : '0;
   end

   // The first pixel after reset is (0,0) itself, so the raster restarts cleanly with a frame_start
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         div_q     <= 3'd0;
         started_q <= 1'b0;
         hcnt_q    <= 9'd0;
         vcnt_q    <= 9'd0;
         fs_q      <= 1'b0;
         hblank_q  <= 1'b0;
         vblank_q  <= 1'b0;
         hsync_q   <= ~HS_POL;
         vsync_q   <= ~VS_POL;
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
      end else begin
         div_q <= div_d;
         fs_q  <= fs_d;
         if (tick) begin
            started_q <= 1'b1;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            hblank_q  <= hblank_d;
            vblank_q  <= vblank_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
         end
      end
   end

   assign vif.ce_pix      = tick;
   assign vif.hcnt        = hcnt_q;
   assign vif.vcnt        = vcnt_q;
   assign vif.hblank      = hblank_q;
   assign vif.vblank      = vblank_q;
   assign vif.HSync       = hsync_q;
   assign vif.VSync       = vsync_q;
   assign vif.frame_start = fs_q;
   assign vif.R           = r_q;
   assign vif.G           = g_q;
   assign vif.B           = b_q;
endmodule
